// File: rtl/bpb_pkg.sv
// bpb_pkg: shared reset values and index hashing for the branch prediction buffer
package bpb_pkg;
  localparam int unsigned DEF_CTR_W = 2;
  localparam int unsigned WEAK_TAKEN_DEF = 32'd1 << (DEF_CTR_W - 1);
  localparam int unsigned WEAK_NOT_TAKEN_DEF = WEAK_TAKEN_DEF - 1;
  function automatic int unsigned weak_taken(int unsigned w);
    return 32'd1 << (w - 1);
  endfunction
  function automatic int unsigned weak_not_taken(int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction
  // Alternating init lets both directions train equally fast from reset.
  function automatic int unsigned ctr_init(int unsigned i, int unsigned w);
    return i[0] ? weak_taken(w) : weak_not_taken(w);
  endfunction
  function automatic logic [31:0] gshare_hash(logic [31:0] pc, logic [31:0] ghr, logic mode);
    return mode ? pc ^ ghr : pc;
  endfunction
endpackage

// File: rtl/bpb_sat_ctr_next.sv
// bpb_sat_ctr_next: next value of a W-bit saturating up/down counter
module bpb_sat_ctr_next #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr_i,
  input  logic         inc_i,
  output logic [W-1:0] ctr_o
);
  always_comb ctr_o = inc_i ? ((&ctr_i) ? ctr_i : ctr_i + 1'b1) : ((|ctr_i) ? ctr_i - 1'b1 : ctr_i);
endmodule

// File: rtl/bpb_gshare.sv
// bpb_gshare: bimodal/gshare branch prediction buffer with history repair and perf counters
module bpb_gshare
  import bpb_pkg::*;
#(
  parameter int IDX_W     = 3,
  parameter int CTR_W     = 2,
  parameter int GHR_W     = 3,
  parameter int HASH_MODE = 1,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              Dis_BpbBranch,
  input  logic [IDX_W-1:0]  Dis_BpbBranchPCBits,
  output logic              Bpb_BranchPrediction,
  output logic [IDX_W-1:0]  Bpb_PredIndex,
  output logic [GHR_W-1:0]  Bpb_GhrSnapshot,
  input  logic              Dis_CdbUpdBranch,
  input  logic [IDX_W-1:0]  Dis_CdbUpdBranchAddr,
  input  logic              Dis_CdbBranchOutcome,
  input  logic              Dis_CdbBranchMispredict,
  input  logic [GHR_W-1:0]  Dis_CdbGhrSnapshot,
  output logic [PERF_W-1:0] Bpb_PredCnt,
  output logic [PERF_W-1:0] Bpb_MispredCnt
);
  localparam int DEPTH = 2 ** IDX_W;
  logic [CTR_W-1:0]  tbl_q [DEPTH];
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [PERF_W-1:0] pred_cnt_q, pred_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [CTR_W-1:0]  upd_new, ctr_eff;
  logic              repair;
  bpb_sat_ctr_next #(.W(CTR_W)) u_next (
    .ctr_i (tbl_q[Dis_CdbUpdBranchAddr]),
    .inc_i (Dis_CdbBranchOutcome),
    .ctr_o (upd_new)
  );
  // A same-cycle write to the read index is forwarded so dispatch sees trained state.
  always_comb begin
    Bpb_PredIndex = IDX_W'(gshare_hash(32'(Dis_BpbBranchPCBits), 32'(ghr_q), HASH_MODE != 0));
    Bpb_GhrSnapshot = ghr_q;
    ctr_eff = (Dis_CdbUpdBranch && Dis_CdbUpdBranchAddr == Bpb_PredIndex) ? upd_new : tbl_q[Bpb_PredIndex];
    Bpb_BranchPrediction = Dis_BpbBranch & ctr_eff[CTR_W-1];
    repair = Dis_CdbUpdBranch & Dis_CdbBranchMispredict;
    ghr_d = repair ? GHR_W'({Dis_CdbGhrSnapshot, Dis_CdbBranchOutcome}) :
            Dis_BpbBranch ? GHR_W'({ghr_q, Bpb_BranchPrediction}) : ghr_q;
    pred_cnt_d = pred_cnt_q + PERF_W'(Dis_BpbBranch && !(&pred_cnt_q));
    mis_cnt_d = mis_cnt_q + PERF_W'(repair && !(&mis_cnt_q));
    Bpb_PredCnt = pred_cnt_q;
    Bpb_MispredCnt = mis_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CTR_W'(ctr_init(i, CTR_W));
      ghr_q <= '0;
      pred_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (Dis_CdbUpdBranch) tbl_q[Dis_CdbUpdBranchAddr] <= upd_new;
      ghr_q <= ghr_d;
      pred_cnt_q <= pred_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
endmodule
